// File: rtl/tdc_multi.sv
// Multi-channel time-to-digital converter: per-channel edge timestamp + pulse width, one shared readout register.
// Optional timeout (ends a measurement at MAX_TOT clocks) is compiled in with `define TDC_TIMEOUT_EN.

module tdc_channel #(
    parameter int TS_W  = 32,
    parameter int TOT_W = 32
`ifdef TDC_TIMEOUT_EN
    ,
    parameter int unsigned MAX_TOT = 125000
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             trigger,
    input  logic             enable,
    input  logic [TS_W-1:0]  ts_now,
    input  logic             grant,
    output logic             busy,
    output logic             pending,
    output logic [TS_W-1:0]  ts,
    output logic [TOT_W-1:0] tot
);
    typedef enum logic [1:0] {IDLE, MEASURE, PENDING} state_t;

    state_t           state, state_nxt;
    logic             trig_q;
    logic [TS_W-1:0]  ts_q, ts_nxt;
    logic [TOT_W-1:0] tot_q, tot_nxt;
    logic             rise;

`ifdef TDC_TIMEOUT_EN
    localparam logic [TOT_W-1:0] TOT_LIMIT = TOT_W'(MAX_TOT);
`endif

    assign rise = trigger & ~trig_q;

    // trig_q keeps sampling through reset so a trigger held high across reset is not an edge
    always_ff @(posedge clk) begin
        trig_q <= trigger;
        if (reset) begin
            state <= IDLE;
            ts_q  <= '0;
            tot_q <= '0;
        end else begin
            state <= state_nxt;
            ts_q  <= ts_nxt;
            tot_q <= tot_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ts_nxt    = ts_q;
        tot_nxt   = tot_q;
        case (state)
            IDLE: begin
                if (rise && enable) begin
                    state_nxt = MEASURE;
                    ts_nxt    = ts_now;
                    tot_nxt   = TOT_W'(1);
                end
            end
            MEASURE: begin
                if (!enable) begin
                    state_nxt = IDLE;
                end else if (!trigger) begin
                    state_nxt = PENDING;
                end else begin
                    if (tot_q != '1) tot_nxt = tot_q + 1'b1;
`ifdef TDC_TIMEOUT_EN
                    if (tot_nxt == TOT_LIMIT) state_nxt = PENDING;
`endif
                end
            end
            PENDING: begin
                if (grant) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy    = (state == MEASURE) || (state == PENDING);
    assign pending = (state == PENDING);
    assign ts      = ts_q;
    assign tot     = tot_q;
endmodule

module tdc_multi #(
    parameter int          NCH     = 4,
    parameter int          TS_W    = 32,
    parameter int          TOT_W   = 32,
    parameter int unsigned MAX_TOT = 125000,
    localparam int         CH_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NCH-1:0]   i_trigger,
    input  logic [NCH-1:0]   i_enable_channel,
    input  logic             i_clear,
    output logic             o_hasEvent,
    output logic [NCH-1:0]   o_busy,
    output logic [CH_W-1:0]  o_channel_ID,
    output logic [TS_W-1:0]  o_timestamp,
    output logic [TOT_W-1:0] o_pulseWidth
);
    typedef struct packed {
        logic [CH_W-1:0]  id;
        logic [TS_W-1:0]  ts;
        logic [TOT_W-1:0] tot;
    } evt_t;

    logic [TS_W-1:0]             ts_cnt;
    logic [NCH-1:0]              ch_pending, grant;
    logic [NCH-1:0][TS_W-1:0]    ch_ts;
    logic [NCH-1:0][TOT_W-1:0]   ch_tot;
    logic                        has_event, sel_found;
    evt_t                        evt_q, evt_nxt;

    always_ff @(posedge clk) begin
        if (reset) ts_cnt <= '0;
        else       ts_cnt <= ts_cnt + 1'b1;
    end

    for (genvar n = 0; n < NCH; n++) begin : g_ch
        tdc_channel #(
            .TS_W   (TS_W),
            .TOT_W  (TOT_W)
`ifdef TDC_TIMEOUT_EN
            ,
            .MAX_TOT(MAX_TOT)
`endif
        ) u_ch (
            .clk    (clk),
            .reset  (reset),
            .trigger(i_trigger[n]),
            .enable (i_enable_channel[n]),
            .ts_now (ts_cnt),
            .grant  (grant[n]),
            .busy   (o_busy[n]),
            .pending(ch_pending[n]),
            .ts     (ch_ts[n]),
            .tot    (ch_tot[n])
        );
    end

    // Lowest-index pending channel wins, only while the output register is free
    always_comb begin
        sel_found = 1'b0;
        grant     = '0;
        evt_nxt   = '0;
        if (!has_event) begin
            for (int n = 0; n < NCH; n++) begin
                if (ch_pending[n] && !sel_found) begin
                    sel_found   = 1'b1;
                    grant[n]    = 1'b1;
                    evt_nxt.id  = CH_W'(n);
                    evt_nxt.ts  = ch_ts[n];
                    evt_nxt.tot = ch_tot[n];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            has_event <= 1'b0;
            evt_q     <= '0;
        end else if (has_event) begin
            if (i_clear) has_event <= 1'b0;
        end else if (sel_found) begin
            has_event <= 1'b1;
            evt_q     <= evt_nxt;
        end
    end

    assign o_hasEvent   = has_event;
    assign o_channel_ID = evt_q.id;
    assign o_timestamp  = evt_q.ts;
    assign o_pulseWidth = evt_q.tot;
endmodule

// File: tb/tb_tdc_multi.sv
// Directed + randomized bench for tdc_multi; expected events come from pulse start/length arithmetic.
module tb_tdc_multi;
    localparam int NCH = 4, TS_W = 8, TOT_W = 16, MAX_TOT = 16, CH_W = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [NCH-1:0]   trig = '0;
    logic [NCH-1:0]   en = '1;
    logic             clr = 1'b0;
    logic             has;
    logic [NCH-1:0]   busy;
    logic [CH_W-1:0]  id;
    logic [TS_W-1:0]  ts;
    logic [TOT_W-1:0] tot;

    int vectors = 0, errs = 0, now = 0;

    always #5 clk = ~clk;

    tdc_multi #(.NCH(NCH), .TS_W(TS_W), .TOT_W(TOT_W), .MAX_TOT(MAX_TOT)) dut (
        .clk(clk), .reset(reset), .i_trigger(trig), .i_enable_channel(en), .i_clear(clr),
        .o_hasEvent(has), .o_busy(busy), .o_channel_ID(id), .o_timestamp(ts), .o_pulseWidth(tot)
    );

    // now == DUT counter value seen by inputs driven at this point
    task automatic tick();
        @(posedge clk);
        #1;
        now++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_evt(input string tag, input int eid, input int ets, input int etot);
        check({tag, "_has"}, 32'(has), 32'd1);
        check({tag, "_id"},  32'(id),  32'(eid));
        check({tag, "_ts"},  32'(ts),  32'(ets % 256));
        check({tag, "_tot"}, 32'(tot), 32'(etot));
    endtask

    task automatic wait_evt(input string tag, input int budget);
        int k = 0;
        while (has !== 1'b1 && k < budget) begin
            tick();
            k++;
        end
        check({tag, "_wait"}, 32'(has), 32'd1);
    endtask

    task automatic read_clear();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) tick();
        reset = 1'b0;
        now = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s[NCH], l[NCH];
        int q[$];
        int t0, span, fmin, first;
        logic [NCH-1:0] ren;

        do_reset(3);
        check("rst_has", 32'(has), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_id", 32'(id), 0);
        check("rst_ts", 32'(ts), 0);
        check("rst_tot", 32'(tot), 0);

        // single pulse on ch0 at counter 5, 10 cycles; clear while empty is ignored
        repeat (5) tick();
        trig[0] = 1'b1;
        tick();
        check("single_busy", 32'(busy[0]), 1);
        repeat (9) tick();
        trig[0] = 1'b0;
        tick();
        check("single_lat", 32'(has), 0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check_evt("single", 0, 5, 10);
        repeat (2) tick();
        check_evt("single_hold", 0, 5, 10);
        read_clear();
        check("single_clr", 32'(has), 0);

        // simultaneous edges on ch1/ch3 at counter 20
        while (now < 20) tick();
        trig[1] = 1'b1;
        trig[3] = 1'b1;
        repeat (3) tick();
        trig[1] = 1'b0;
        repeat (4) tick();
        trig[3] = 1'b0;
        wait_evt("sim_a", 10);
        check_evt("sim_a", 1, 20, 3);
        check("sim_busy3", 32'(busy[3]), 1);
        read_clear();
        check("sim_clr", 32'(has), 0);
        tick();
        check_evt("sim_b", 3, 20, 7);
        read_clear();
        tick();
        check("sim_empty", 32'(has), 0);

        // disable abort on ch2
        trig[2] = 1'b1;
        tick();
        check("abort_busy", 32'(busy[2]), 1);
        repeat (3) tick();
        en[2] = 1'b0;
        tick();
        check("abort_idle", 32'(busy[2]), 0);
        repeat (3) tick();
        trig[2] = 1'b0;
        repeat (4) tick();
        check("abort_noevt", 32'(has), 0);
        en[2] = 1'b1;

        // timestamp wrap
        while (now % 256 != 255) tick();
        trig[0] = 1'b1;
        repeat (4) tick();
        trig[0] = 1'b0;
        wait_evt("wrap_a", 8);
        check_evt("wrap_a", 0, 255, 4);
        read_clear();
        while (now % 256 != 2) tick();
        trig[0] = 1'b1;
        tick();
        trig[0] = 1'b0;
        wait_evt("wrap_b", 8);
        check_evt("wrap_b", 0, 2, 1);
        read_clear();
        tick();

`ifdef TDC_TIMEOUT_EN
        t0 = now;
        trig[0] = 1'b1;
        repeat (20) tick();
        check_evt("timeout", 0, t0, MAX_TOT);
        read_clear();
        repeat (20) tick();
        check("to_norearm_has", 32'(has), 0);
        check("to_norearm_busy", 32'(busy[0]), 0);
        trig[0] = 1'b0;
        tick();
        t0 = now;
        trig[0] = 1'b1;
        repeat (2) tick();
        trig[0] = 1'b0;
        wait_evt("to_rearm", 8);
        check_evt("to_rearm", 0, t0, 2);
        read_clear();
        tick();
`endif

        // randomized rounds: concurrent pulses with random start, length, enable
        for (int r = 0; r < 30; r++) begin
            t0 = now;
            span = 0;
            for (int c = 0; c < NCH; c++) begin
                ren[c] = ($urandom_range(0, 4) != 0);
                s[c] = $urandom_range(0, 4);
                l[c] = $urandom_range(1, 8);
                if (s[c] + l[c] > span) span = s[c] + l[c];
            end
            en = ren;
            for (int k = 0; k <= span; k++) begin
                for (int c = 0; c < NCH; c++) trig[c] = (k >= s[c] && k < s[c] + l[c]);
                tick();
                for (int c = 0; c < NCH; c++)
                    if (k >= s[c] && k < s[c] + l[c])
                        check($sformatf("rnd%0d_busy%0d", r, c), 32'(busy[c]), 32'(ren[c]));
            end
            repeat (3) tick();
            fmin = 1000;
            first = -1;
            for (int c = 0; c < NCH; c++)
                if (ren[c] && s[c] + l[c] < fmin) begin
                    fmin = s[c] + l[c];
                    first = c;
                end
            q.delete();
            if (first >= 0) begin
                q.push_back(first);
                for (int c = 0; c < NCH; c++) if (ren[c] && c != first) q.push_back(c);
            end
            if (q.size() == 0) check($sformatf("rnd%0d_none", r), 32'(has), 0);
            foreach (q[i]) begin
                check_evt($sformatf("rnd%0d_e%0d", r, i), q[i], t0 + s[q[i]], l[q[i]]);
                read_clear();
                check($sformatf("rnd%0d_clr%0d", r, i), 32'(has), 0);
                tick();
            end
            check($sformatf("rnd%0d_idle", r), 32'(busy), 0);
        end
        en = '1;

        // reset during a measurement, with an unread event held
        trig[1] = 1'b1;
        repeat (2) tick();
        trig[1] = 1'b0;
        wait_evt("pre_rst", 8);
        trig[0] = 1'b1;
        repeat (3) tick();
        check("pre_rst_busy", 32'(busy[0]), 1);
        do_reset(2);
        check("mid_rst_has", 32'(has), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_id", 32'(id), 0);
        check("mid_rst_ts", 32'(ts), 0);
        check("mid_rst_tot", 32'(tot), 0);
        repeat (5) tick();
        check("post_rst_busy", 32'(busy), 0);
        check("post_rst_has", 32'(has), 0);
        trig[0] = 1'b0;
        tick();
        trig[0] = 1'b1;
        repeat (2) tick();
        trig[0] = 1'b0;
        wait_evt("post_rst", 8);
        check_evt("post_rst", 0, 6, 2);
        read_clear();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

// File: doc/tdc_multi.md
TDC_MULTI -- requirements
Module: tdc_multi

Interface
REQ-001 SHALL have parameter NCH, default 4: number of trigger channels (1..16).
REQ-002 SHALL have parameter TS_W, default 32: timestamp width.
REQ-003 SHALL have parameter TOT_W, default 32: pulse-width width.
REQ-004 SHALL have parameter MAX_TOT, default 125000: timeout limit in clocks (used only under REQ-027).
REQ-005 SHALL have port clk, input, 1: single clock for all logic.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port i_trigger, input, NCH: per-channel pulse inputs, synchronous to clk.
REQ-008 SHALL have port i_enable_channel, input, NCH: per-channel arm enable.
REQ-009 SHALL have port i_clear, input, 1: readout acknowledge.
REQ-010 SHALL have port o_hasEvent, output, 1: output registers hold a valid event.
REQ-011 SHALL have port o_busy, output, NCH: channel is measuring or holding an unread event.
REQ-012 SHALL have port o_channel_ID, output, CH_W = max(1, clog2(NCH)): source channel of the presented event.
REQ-013 SHALL have port o_timestamp, output, TS_W: counter value at rising edge.
REQ-014 SHALL have port o_pulseWidth, output, TOT_W: trigger-high duration in clocks.

Function
REQ-015 SHALL run a free-running TS_W counter: 0 at the first cycle after reset, +1 per clock, wrapping from all-ones to 0.
REQ-016 SHALL give each channel an FSM with states IDLE, MEASURE and PENDING.
- IDLE->MEASURE: i_trigger[n]=1 with previous sample 0 and i_enable_channel[n]=1; captures the counter value; sets TOT=1.
- MEASURE: TOT increments each cycle trigger stays high, saturating at 2^TOT_W-1.
- MEASURE->PENDING: trigger sampled 0.
- PENDING->IDLE: when the event is transferred to the output registers.
REQ-017 SHALL set o_pulseWidth equal to the number of cycles i_trigger[n] was sampled high (a 1-cycle pulse reports 1).
REQ-018 SHALL assert o_busy[n] exactly in MEASURE and PENDING; with a rising edge sampled at cycle t, o_busy[n]=1 from t+1.
REQ-019 SHALL abort to IDLE with no event when i_enable_channel[n]=0 during MEASURE; PENDING events are kept.
REQ-020 SHALL ignore trigger edges in MEASURE and PENDING; a new measurement requires IDLE and a fresh rising edge.
REQ-021 SHALL, when o_hasEvent=0 and at least one channel is PENDING, load the lowest-index PENDING channel into o_channel_ID/o_timestamp/o_pulseWidth and assert o_hasEvent the next cycle.
- Result: falling edge sampled at cycle f gives o_hasEvent=1 at f+2 when the output is free.
REQ-022 SHALL hold the output registers stable while o_hasEvent=1; i_clear=1 drops o_hasEvent the next cycle, and the next PENDING event may load the cycle after that.
REQ-023 SHALL ignore i_clear while o_hasEvent=0.
REQ-024 SHALL process edges on different channels in the same cycle independently; each channel's event is read in index order.

Reset
REQ-025 SHALL, while reset=1, force all channels to IDLE, the counter to 0, o_hasEvent=0, o_busy=0, and o_channel_ID, o_timestamp and o_pulseWidth to 0.
REQ-026 SHALL discard measurements in progress at reset; a trigger still high after reset does not start a measurement until it is sampled low and then high.

Configuration
REQ-027 SHALL compile timeout logic only when macro TDC_TIMEOUT_EN is defined.
- With TDC_TIMEOUT_EN: TOT reaching MAX_TOT in MEASURE moves the channel to PENDING with o_pulseWidth=MAX_TOT; the channel then stays non-rearmable until its trigger is sampled low.
- Without TDC_TIMEOUT_EN: no timeout; behaviour per REQ-016 saturation only.

Verification
REQ-028 SHALL cover single pulse: reset released, ch0 high 10 cycles starting at counter=5 -> o_hasEvent=1, ID=0, TS=5, TOT=10; i_clear -> o_hasEvent=0 next cycle.
REQ-029 SHALL cover simultaneous events: ch1 and ch3 both rise at counter=20, high 3 and 7 cycles -> events read in order ID=1 (TS=20, TOT=3) then ID=3 (TS=20, TOT=7), each after one i_clear.
REQ-030 SHALL cover disable abort: ch2 rises, i_enable_channel[2]=0 after 4 cycles -> o_busy[2]=0 next cycle, no event produced.
REQ-031 SHALL cover wrap: TS_W=8, rising edge at counter=255, pulse length 4 -> TS=255, TOT=4; the next rising edge at counter value 2 reports TS=2.
REQ-032 SHALL cover timeout with TDC_TIMEOUT_EN and MAX_TOT=16: trigger held 40 cycles -> TOT=16 event; no second event until trigger falls and rises again.
REQ-033 SHALL cover reset mid-measurement: reset pulsed while ch0 is in MEASURE with the trigger still high -> all outputs 0, no event until a new rising edge.
